vga_pixel_out: RTL and testbench

Pixel-clock-domain VGA output stage that sits directly downstream of the read side of the pixel async FIFO. It generates horizontal/vertical timing and pops one FIFO word per active pixel, using the FIFO's non-show-ahead read, where data appears one cycle after the pop. It drives registered pixel data, syncs and blank to the DAC/HDMI pins. Underflow is handled cleanly and reported.

---
 rtl/vga_pixel_out.sv | 103 ++++++++++
 tb/tb_vga_pixel_out.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: VGA timing generator and output stage fed by a non-show-ahead FIFO.
// Pops one word per active pixel; data, syncs and blank leave two cycles after the counters.
module vga_pixel_out #(
  parameter int   DATA_W   = 24,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic w_run, w_h_last, w_v_last, w_de0, w_hs0, w_vs0, w_fs0, w_miss;
  logic r_de1, r_hs1, r_vs1, r_fs1, r_pop1;
  logic [DATA_W-1:0] r_pix;
  logic r_hs, r_vs, r_blank_n, r_fs, r_uf;
  logic [15:0] r_uf_cnt;
  assign w_run    = r_state == RUN;
  assign w_h_last = r_h_cnt == H_LAST;
  assign w_v_last = r_v_cnt == V_LAST;
  assign w_de0 = w_run && int'(r_h_cnt) < H_ACTIVE && int'(r_v_cnt) < V_ACTIVE;
  assign w_hs0 = w_run && int'(r_h_cnt) >= H_ACTIVE + H_FP && int'(r_h_cnt) < H_ACTIVE + H_FP + H_SYNC;
  assign w_vs0 = w_run && int'(r_v_cnt) >= V_ACTIVE + V_FP && int'(r_v_cnt) < V_ACTIVE + V_FP + V_SYNC;
  assign w_fs0 = w_run && r_h_cnt == '0 && r_v_cnt == '0;
  assign fifo_rd_valid = w_de0 && !fifo_empty;
  assign w_miss = w_de0 && fifo_empty;
  // Leaving RUN is only allowed on the last pixel of a frame so frames are never cut short.
  always_comb begin
    w_next = (r_state == IDLE) ? (enable ? RUN : IDLE) : ((w_h_last && w_v_last && !enable) ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!reset_n || !w_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + HW'(1);
      if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {r_de1, r_hs1, r_vs1, r_fs1, r_pop1} <= '0;
      r_pix     <= '0;
      r_blank_n <= 1'b0;
      r_hs      <= ~SYNC_POL;
      r_vs      <= ~SYNC_POL;
      r_fs      <= 1'b0;
    end else begin
      {r_de1, r_hs1, r_vs1, r_fs1, r_pop1} <= {w_de0, w_hs0, w_vs0, w_fs0, fifo_rd_valid};
      r_pix     <= r_pop1 ? fifo_rd_data : '0;
      r_blank_n <= r_de1;
      r_hs      <= r_hs1 ? SYNC_POL : ~SYNC_POL;
      r_vs      <= r_vs1 ? SYNC_POL : ~SYNC_POL;
      r_fs      <= r_fs1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_uf     <= 1'b0;
      r_uf_cnt <= '0;
    end else begin
      r_uf     <= r_uf | w_miss;
      r_uf_cnt <= (w_miss && r_uf_cnt != 16'hFFFF) ? r_uf_cnt + 16'd1 : r_uf_cnt;
    end
  end
  assign pix_data      = r_pix;
  assign vga_hs        = r_hs;
  assign vga_vs        = r_vs;
  assign vga_blank_n   = r_blank_n;
  assign frame_start   = r_fs;
  assign underflow     = r_uf;
  assign underflow_cnt = r_uf_cnt;
endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: directed bench for vga_pixel_out with a tiny 8x6 raster and a 12-word FIFO model.
module tb_vga_pixel_out;
  logic clk = 1'b0;
  logic reset_n, enable, force_empty;
  logic fifo_empty, rv, hs, vs, blank_n, fs, uf;
  logic [23:0] fifo_rd_data, pix;
  logic [15:0] ufc;
  logic rv_p, hs_p, vs_p, blank_p, fs_p, uf_p;
  logic [23:0] pix_p;
  logic [15:0] ufc_p;
  int rd_ptr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vga_pixel_out #(.DATA_W(24), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(rv), .pix_data(pix), .vga_hs(hs),
    .vga_vs(vs), .vga_blank_n(blank_n), .frame_start(fs), .underflow(uf), .underflow_cnt(ufc));
  vga_pixel_out #(.DATA_W(24), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut_p (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(rv_p), .pix_data(pix_p), .vga_hs(hs_p),
    .vga_vs(vs_p), .vga_blank_n(blank_p), .frame_start(fs_p), .underflow(uf_p), .underflow_cnt(ufc_p));
  // FIFO model holding words 1..12; read data appears the cycle after a pop.
  assign fifo_empty = force_empty || rd_ptr >= 12;
  always @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= 0;
      fifo_rd_data <= '0;
    end else if (rv) begin
      rd_ptr <= rd_ptr + 1;
      fifo_rd_data <= 24'(rd_ptr + 1);
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Expected values for an uninterrupted first frame starting at cycle 0 with 12 words loaded.
  function automatic bit exp_rv(int k);
    return k < 24 && k % 8 < 4 && k / 8 < 3;
  endfunction
  function automatic bit exp_blank(int k);
    return k >= 2 && (k - 2) % 8 < 4 && ((k - 2) / 8) % 6 < 3;
  endfunction
  function automatic logic [23:0] exp_pix(int k);
    int s = k - 2;
    return (s >= 0 && s < 24 && s % 8 < 4) ? 24'((s / 8) * 4 + s % 8 + 1) : 24'd0;
  endfunction
  function automatic bit exp_hs_act(int k);
    return k >= 2 && ((k - 2) % 8 == 5 || (k - 2) % 8 == 6);
  endfunction
  function automatic bit exp_vs_act(int k);
    return k >= 2 && ((k - 2) / 8) % 6 == 4;
  endfunction
  task automatic start_run;
    reset_n = 1'b0; enable = 1'b0; force_empty = 1'b0;
    repeat (3) tick;
    reset_n = 1'b1; enable = 1'b1;
    tick;
  endtask
  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; force_empty = 1'b0;
    repeat (3) tick;
    checks++; if (pix !== 24'd0) begin errors++; $display("FAIL reset pix got=%0h exp=0", pix); end
    checks++; if (blank_n !== 1'b0) begin errors++; $display("FAIL reset blank_n got=%b exp=0", blank_n); end
    checks++; if (hs !== 1'b1 || vs !== 1'b1) begin errors++; $display("FAIL reset syncs got=%b%b exp=11", hs, vs); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset rd_valid got=%b exp=0", rv); end
    checks++; if (ufc !== 16'd0 || uf !== 1'b0) begin errors++; $display("FAIL reset underflow got=%b/%0d exp=0/0", uf, ufc); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset frame_start got=%b exp=0", fs); end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++; if (rv !== 1'b0 || hs !== 1'b1) begin errors++; $display("FAIL idle cyc=%0d rv/hs got=%b/%b exp=0/1", k, rv, hs); end
    end
  endtask
  task automatic test_frame;
    start_run;
    for (int k = 0; k <= 51; k++) begin
      #1;
      checks++; if (rv !== (k < 48 && exp_rv(k))) begin errors++; $display("FAIL frame rd_valid cyc=%0d got=%b exp=%b", k, rv, exp_rv(k)); end
      checks++; if (pix !== exp_pix(k)) begin errors++; $display("FAIL frame pix cyc=%0d got=%0h exp=%0h", k, pix, exp_pix(k)); end
      checks++; if (blank_n !== exp_blank(k)) begin errors++; $display("FAIL frame blank_n cyc=%0d got=%b exp=%b", k, blank_n, exp_blank(k)); end
      checks++; if (hs !== !exp_hs_act(k)) begin errors++; $display("FAIL frame hs cyc=%0d got=%b exp=%b", k, hs, !exp_hs_act(k)); end
      checks++; if (vs !== !exp_vs_act(k)) begin errors++; $display("FAIL frame vs cyc=%0d got=%b exp=%b", k, vs, !exp_vs_act(k)); end
      checks++; if (fs !== (k == 2 || k == 50)) begin errors++; $display("FAIL frame frame_start cyc=%0d got=%b", k, fs); end
      tick;
    end
  endtask
  task automatic test_underflow;
    logic [23:0] e;
    start_run;
    for (int k = 0; k <= 21; k++) begin
      force_empty = (k == 9);
      #1;
      e = 24'd0;
      if (k >= 2 && k <= 5) e = 24'(k - 1);
      if (k == 10) e = 24'd5;
      if (k == 12) e = 24'd6;
      if (k == 13) e = 24'd7;
      if (k >= 18) e = 24'(k - 10);
      checks++; if (rv !== (exp_rv(k) && k != 9)) begin errors++; $display("FAIL uf rd_valid cyc=%0d got=%b exp=%b", k, rv, exp_rv(k) && k != 9); end
      checks++; if (pix !== e) begin errors++; $display("FAIL uf pix cyc=%0d got=%0h exp=%0h", k, pix, e); end
      checks++; if (blank_n !== exp_blank(k)) begin errors++; $display("FAIL uf blank_n cyc=%0d got=%b exp=%b", k, blank_n, exp_blank(k)); end
      checks++; if (hs !== !exp_hs_act(k)) begin errors++; $display("FAIL uf hs cyc=%0d got=%b exp=%b", k, hs, !exp_hs_act(k)); end
      checks++; if (uf !== (k >= 10)) begin errors++; $display("FAIL uf flag cyc=%0d got=%b exp=%b", k, uf, k >= 10); end
      checks++; if (ufc !== ((k >= 10) ? 16'd1 : 16'd0)) begin errors++; $display("FAIL uf count cyc=%0d got=%0d exp=%0d", k, ufc, k >= 10); end
      tick;
    end
    force_empty = 1'b0;
  endtask
  task automatic test_enable_drop;
    start_run;
    for (int k = 0; k <= 60; k++) begin
      if (k == 20) enable = 1'b0;
      #1;
      checks++; if (rv !== exp_rv(k)) begin errors++; $display("FAIL drop rd_valid cyc=%0d got=%b exp=%b", k, rv, exp_rv(k)); end
      if (k >= 50) begin
        checks++; if (hs !== 1'b1 || vs !== 1'b1) begin errors++; $display("FAIL drop syncs cyc=%0d got=%b%b exp=11", k, hs, vs); end
        checks++; if (blank_n !== 1'b0) begin errors++; $display("FAIL drop blank_n cyc=%0d got=%b exp=0", k, blank_n); end
      end
      checks++; if (fs !== (k == 2)) begin errors++; $display("FAIL drop frame_start cyc=%0d got=%b exp=%b", k, fs, k == 2); end
      tick;
    end
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL drop underflow got=%b exp=0", uf); end
  endtask
  task automatic test_midline_reset;
    start_run;
    for (int k = 0; k <= 17; k++) begin
      if (k == 10) reset_n = 1'b0;
      if (k == 11) reset_n = 1'b1;
      #1;
      if (k < 10) begin
        checks++; if (pix !== exp_pix(k)) begin errors++; $display("FAIL rst pix cyc=%0d got=%0h exp=%0h", k, pix, exp_pix(k)); end
      end
      if (k == 11) begin
        checks++; if (pix !== 24'd0 || blank_n !== 1'b0 || fs !== 1'b0) begin errors++; $display("FAIL rst outputs pix/blank/fs got=%0h/%b/%b exp=0/0/0", pix, blank_n, fs); end
        checks++; if (hs !== 1'b1 || vs !== 1'b1) begin errors++; $display("FAIL rst syncs got=%b%b exp=11", hs, vs); end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL rst rd_valid got=%b exp=0", rv); end
      end
      if (k == 12) begin
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL rst first pop got=%b exp=1", rv); end
      end
      if (k >= 14) begin
        checks++; if (pix !== 24'(k - 13) || blank_n !== 1'b1) begin errors++; $display("FAIL rst restart pix cyc=%0d got=%0h/%b exp=%0h/1", k, pix, blank_n, k - 13); end
      end
      if (k == 14) begin
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL rst frame_start got=%b exp=1", fs); end
      end
      tick;
    end
  endtask
  task automatic test_sync_pol;
    reset_n = 1'b0; enable = 1'b0; force_empty = 1'b0;
    repeat (3) tick;
    checks++; if (hs_p !== 1'b0 || vs_p !== 1'b0) begin errors++; $display("FAIL pol reset syncs got=%b%b exp=00", hs_p, vs_p); end
    checks++; if (pix_p !== 24'd0 || blank_p !== 1'b0 || fs_p !== 1'b0) begin errors++; $display("FAIL pol reset outputs got=%0h/%b/%b exp=0/0/0", pix_p, blank_p, fs_p); end
    checks++; if (rv_p !== 1'b0 || uf_p !== 1'b0 || ufc_p !== 16'd0) begin errors++; $display("FAIL pol reset rv/uf got=%b/%b/%0d exp=0/0/0", rv_p, uf_p, ufc_p); end
    reset_n = 1'b1; enable = 1'b1;
    tick;
    for (int k = 0; k <= 45; k++) begin
      #1;
      checks++; if (hs_p !== exp_hs_act(k)) begin errors++; $display("FAIL pol hs cyc=%0d got=%b exp=%b", k, hs_p, exp_hs_act(k)); end
      checks++; if (vs_p !== exp_vs_act(k)) begin errors++; $display("FAIL pol vs cyc=%0d got=%b exp=%b", k, vs_p, exp_vs_act(k)); end
      checks++; if (pix_p !== exp_pix(k)) begin errors++; $display("FAIL pol pix cyc=%0d got=%0h exp=%0h", k, pix_p, exp_pix(k)); end
      tick;
    end
  endtask
  initial begin
    reset_n = 1'b0; enable = 1'b0; force_empty = 1'b0;
    test_reset;
    test_frame;
    test_underflow;
    test_enable_drop;
    test_midline_reset;
    test_sync_pol;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
